// File: rtl/width_pack_stage.sv
// Packs N consecutive L-bit beats into one N*L-bit word on a registered valid/ready output.
// A flush emits the partially filled word with its unfilled lanes zeroed.
module width_pack_stage #(
  parameter int L  = 8,
  parameter int N  = 4,
  localparam int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  output logic           ready_f,
  input  logic           valid_f,
  input  logic [L-1:0]   data_f,
  input  logic           flush,
  input  logic           ready_b,
  output logic           valid_b,
  output logic [N*L-1:0] data_b,
  output logic [CW-1:0]  cnt_b,
  output logic           flush_done
);

  logic [N*L-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [N*L-1:0] data_q, data_d;
  logic [CW-1:0]  cntb_q, cntb_d;
  logic           fdone_q, fdone_d;

  logic           slot_free;
  logic           acc_in;
  logic [CW-1:0]  cnt_nx;
  logic [N*L-1:0] word_nx;
  logic           emit;

  assign slot_free = !valid_q || ready_b;
  // With a flush pending the accumulator is frozen until the output slot opens.
  assign ready_f   = slot_free || ((cnt_q != CW'(N-1)) && !flush);
  assign acc_in    = valid_f && ready_f;
  assign cnt_nx    = cnt_q + CW'(acc_in);
  assign emit      = slot_free && ((cnt_nx == CW'(N)) || (flush && (cnt_nx != '0)));

  always_comb begin
    word_nx = acc_q;
    for (int k = 0; k < N; k++) begin
      if (acc_in && (cnt_q == CW'(k))) word_nx[k*L +: L] = data_f;
      if (CW'(k) >= cnt_nx)            word_nx[k*L +: L] = '0;
    end
  end

  always_comb begin
    acc_d   = word_nx;
    cnt_d   = cnt_nx;
    valid_d = valid_q;
    data_d  = data_q;
    cntb_d  = cntb_q;
    fdone_d = flush && slot_free;
    if (emit) begin
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b1;
      data_d  = word_nx;
      cntb_d  = cnt_nx;
    end else if (valid_q && ready_b) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cntb_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cntb_q  <= cntb_d;
      fdone_q <= fdone_d;
    end
  end

  assign valid_b    = valid_q;
  assign data_b     = data_q;
  assign cnt_b      = cntb_q;
  assign flush_done = fdone_q;

endmodule

// File: tb/tb_width_pack_stage.sv
// Bench for width_pack_stage: directed scenarios plus random traffic against a queue-based model.
module tb_width_pack_stage;
  localparam int L  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           ready_f;
  logic           valid_f;
  logic [L-1:0]   data_f;
  logic           flush;
  logic           ready_b;
  logic           valid_b;
  logic [N*L-1:0] data_b;
  logic [CW-1:0]  cnt_b;
  logic           flush_done;

  width_pack_stage #(.L(L), .N(N)) dut (
    .clk(clk), .rst(rst), .ready_f(ready_f), .valid_f(valid_f), .data_f(data_f),
    .flush(flush), .ready_b(ready_b), .valid_b(valid_b), .data_b(data_b),
    .cnt_b(cnt_b), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: beats accepted but not yet emitted, plus the output register contents.
  logic [L-1:0]   q[$];
  bit             m_valid;
  logic [N*L-1:0] m_data;
  int             m_cnt;
  bit             m_fd;

  task automatic model_reset();
    q.delete();
    m_valid = 0;
    m_data  = '0;
    m_cnt   = 0;
    m_fd    = 0;
  endtask

  task automatic check_outputs();
    chk("valid_b", valid_b, m_valid);
    chk("data_b", data_b, m_data);
    chk("cnt_b", cnt_b, m_cnt);
    chk("flush_done", flush_done, m_fd);
  endtask

  // One clock cycle: drive inputs, check ready_f, advance the model, check outputs after the edge.
  task automatic step(input bit vf, input logic [L-1:0] df, input bit fl, input bit rb);
    bit sf, er;
    valid_f = vf; data_f = df; flush = fl; ready_b = rb;
    #1;
    sf = !m_valid || rb;
    er = sf || (q.size() != N-1 && !fl);
    chk("ready_f", ready_f, er);
    if (vf && er) q.push_back(df);
    m_fd = fl && sf;
    if (sf && (q.size() == N || (fl && q.size() > 0))) begin
      m_data = '0;
      foreach (q[i]) m_data[i*L +: L] = q[i];
      m_cnt   = q.size();
      m_valid = 1;
      q.delete();
    end else if (m_valid && rb) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b0; valid_f = 0; data_f = '0; flush = 0; ready_b = 1;
    model_reset();
    #12;
    check_outputs();
    chk("reset_ready_f", ready_f, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Four beats pack into lane order, word valid right after the 4th beat.
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1);
    step(1, 8'h44, 0, 1);
    chk("t1_data", data_b, 32'h44332211);
    chk("t1_cnt", cnt_b, 4);
    chk("t1_valid", valid_b, 1'b1);

    // Continuous 16 beats with an always-ready consumer.
    for (int i = 0; i < 16; i++) step(1, 8'(i * 7 + 3), 0, 1);
    step(0, 0, 0, 1);

    // Downstream stall: first word held, ready_f drops at cnt==3, then releases.
    for (int i = 0; i < 4; i++) step(1, 8'h50 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
    chk("t3_hold", data_b, 32'h53525150);
    step(1, 8'h63, 0, 1);
    chk("t3_second", data_b, 32'h63626160);
    step(0, 0, 0, 1);

    // Partial flush.
    step(1, 8'hA1, 0, 1);
    step(1, 8'hB2, 0, 1);
    step(0, 0, 1, 1);
    chk("t4_data", data_b, 32'h0000B2A1);
    chk("t4_cnt", cnt_b, 2);
    chk("t4_fd", flush_done, 1'b1);
    step(0, 0, 0, 1);
    chk("t4_fd_pulse", flush_done, 1'b0);
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 0, 1);
    chk("t4_lane0", data_b, 32'hC3C2C1C0);

    // Empty flush.
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("t5_fd", flush_done, 1'b1);
    chk("t5_valid", valid_b, 1'b0);
    step(0, 0, 0, 1);

    // Reset mid-word with a held word on the output.
    for (int i = 0; i < 4; i++) step(1, 8'h70 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h80 + 8'(i), 0, 0);
    rst = 1'b0;
    #1;
    chk("t6_valid_async", valid_b, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 8'h90 + 8'(i), 0, 1);
    chk("t6_new_word", data_b, 32'h93929190);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) == 0, ($urandom % 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
